// File: rtl/phase_pwm_pkg.sv
// -----------------------------------------------------------------------------
// phase_pwm_pkg
//   Shared definitions for the three-phase centre-aligned PWM generator:
//   carrier state encoding, default widths/limits and phase bit positions
//   within pwm_hi.
// -----------------------------------------------------------------------------
package phase_pwm_pkg;

    // Default width of carrier, period and compare values.
    localparam int N_DEF          = 12;
    // Smallest legal carrier half-period in clocks.
    localparam int PERIOD_MIN_DEF = 2;

    // Bit positions of each phase inside pwm_hi.
    localparam int PH_A = 0;
    localparam int PH_B = 1;
    localparam int PH_C = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

endpackage

// File: rtl/phase_pwm_gen_tri_carrier.sv
// -----------------------------------------------------------------------------
// tri_carrier
//   Triangle carrier for the centre-aligned PWM: counts 0..P..1 repeatedly
//   while en is high, held at 0 in IDLE.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     en          : run enable, low forces IDLE on the next edge
//     period      : active half-period P (already clamped by the caller)
//     carrier     : registered carrier value
//     valley/peak : registered one-cycle pulses aligned with carrier 0 / P
//     down        : carrier is on its falling slope (state DOWN)
//     idle        : state is IDLE
//     valley_evt  : combinational, high in the cycle before a valley pulse;
//                   the caller uses it to load new values at the same edge
//                   the carrier returns to 0
// -----------------------------------------------------------------------------
module tri_carrier
    import phase_pwm_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] period,
    output logic [N-1:0] carrier,
    output logic         valley,
    output logic         peak,
    output logic         down,
    output logic         idle,
    output logic         valley_evt
);

    localparam logic [N-1:0] ONE = N'(1);

    state_e       state_q, state_d;
    logic [N-1:0] carrier_q, carrier_d;
    logic         valley_q, valley_d;
    logic         peak_q, peak_d;

    always_comb begin
        state_d   = state_q;
        carrier_d = carrier_q;
        valley_d  = 1'b0;
        peak_d    = 1'b0;
        if (!en) begin
            state_d   = IDLE;
            carrier_d = '0;
        end else begin
            unique case (state_q)
                // Start from 0 going up; this first 0 is not a valley.
                IDLE: begin
                    state_d   = UP;
                    carrier_d = '0;
                end
                UP: begin
                    if (carrier_q == period - ONE) begin
                        state_d   = DOWN;
                        carrier_d = period;
                        peak_d    = 1'b1;
                    end else begin
                        carrier_d = carrier_q + ONE;
                    end
                end
                DOWN: begin
                    if (carrier_q == ONE) begin
                        state_d   = UP;
                        carrier_d = '0;
                        valley_d  = 1'b1;
                    end else begin
                        carrier_d = carrier_q - ONE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    carrier_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            carrier_q <= '0;
            valley_q  <= 1'b0;
            peak_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            carrier_q <= carrier_d;
            valley_q  <= valley_d;
            peak_q    <= peak_d;
        end
    end

    assign carrier    = carrier_q;
    assign valley     = valley_q;
    assign peak       = peak_q;
    assign down       = (state_q == DOWN);
    assign idle       = (state_q == IDLE);
    assign valley_evt = valley_d;

endmodule

// File: rtl/phase_pwm_gen.sv
// -----------------------------------------------------------------------------
// phase_pwm_gen
//   Three-phase centre-aligned PWM generator. A triangle carrier is compared
//   against three active compare values; new period/compare sets are taken
//   through a valid/ready shadow register and become active only at a carrier
//   valley (or at once while idle), so a running period is never disturbed.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     en                : run enable
//     cmp_valid         : new set offered
//     cmp_ready         : shadow free; an offer is accepted this cycle
//     period_in         : requested half-period (clamped to >= PERIOD_MIN)
//     cmp_a/cmp_b/cmp_c : phase compare values
//     pwm_hi[2:0]       : registered high-side commands, bit 0 = phase A
//     carrier           : current carrier value
//     valley / peak     : one-cycle pulses at carrier 0 (turning up) / P
// -----------------------------------------------------------------------------
module phase_pwm_gen
    import phase_pwm_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int PERIOD_MIN = PERIOD_MIN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cmp_valid,
    output logic         cmp_ready,
    input  logic [N-1:0] period_in,
    input  logic [N-1:0] cmp_a,
    input  logic [N-1:0] cmp_b,
    input  logic [N-1:0] cmp_c,
    output logic [2:0]   pwm_hi,
    output logic [N-1:0] carrier,
    output logic         valley,
    output logic         peak
);

    localparam logic [N-1:0] PMIN = N'(PERIOD_MIN);

    function automatic logic [N-1:0] clamp_period(input logic [N-1:0] p);
        return (p < PMIN) ? PMIN : p;
    endfunction

    // Falling slope compares against carrier-1 (i.e. carrier <= c) so that
    // each slope contributes c cycles and the pulse is 2*c clocks wide,
    // straddling the valley.
    function automatic logic phase_on(input logic [N-1:0] c,
                                      input logic [N-1:0] p,
                                      input logic [N-1:0] car,
                                      input logic         dn);
        if (c == '0) return 1'b0;
        if (c >= p)  return 1'b1;
        return dn ? (car <= c) : (car < c);
    endfunction

    logic               pending_q, pending_d;
    logic [N-1:0]       sh_period_q, sh_period_d;
    logic [2:0][N-1:0]  sh_cmp_q, sh_cmp_d;
    logic [N-1:0]       act_period_q, act_period_d;
    logic [2:0][N-1:0]  act_cmp_q, act_cmp_d;
    logic [2:0]         pwm_hi_q, pwm_hi_d;

    logic               accept, load;
    logic               down, idle, valley_evt;

    tri_carrier #(.N(N)) u_carrier (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period     (act_period_q),
        .carrier    (carrier),
        .valley     (valley),
        .peak       (peak),
        .down       (down),
        .idle       (idle),
        .valley_evt (valley_evt)
    );

    always_comb begin
        accept = cmp_valid & ~pending_q;
        // Load needs pending, and accept needs !pending, so an offer landing
        // on a valley cycle never reaches the active set until the next one.
        load   = pending_q & (valley_evt | idle);

        pending_d    = pending_q;
        sh_period_d  = sh_period_q;
        sh_cmp_d     = sh_cmp_q;
        act_period_d = act_period_q;
        act_cmp_d    = act_cmp_q;

        if (load) begin
            act_period_d = sh_period_q;
            act_cmp_d    = sh_cmp_q;
            pending_d    = 1'b0;
        end
        if (accept) begin
            sh_period_d = clamp_period(period_in);
            sh_cmp_d    = {cmp_c, cmp_b, cmp_a};
            pending_d   = 1'b1;
        end

        // Forced low while idle and in the cycle en falls, so outputs are
        // 000 together with the carrier returning to 0.
        pwm_hi_d = '0;
        if (en && !idle) begin
            pwm_hi_d[PH_A] = phase_on(act_cmp_q[PH_A], act_period_q, carrier, down);
            pwm_hi_d[PH_B] = phase_on(act_cmp_q[PH_B], act_period_q, carrier, down);
            pwm_hi_d[PH_C] = phase_on(act_cmp_q[PH_C], act_period_q, carrier, down);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= 1'b0;
            act_period_q <= PMIN;
            act_cmp_q    <= '0;
            pwm_hi_q     <= '0;
        end else begin
            pending_q    <= pending_d;
            act_period_q <= act_period_d;
            act_cmp_q    <= act_cmp_d;
            pwm_hi_q     <= pwm_hi_d;
        end
    end

    // Shadow contents are meaningless without pending, so no reset needed.
    always_ff @(posedge clk) begin
        sh_period_q <= sh_period_d;
        sh_cmp_q    <= sh_cmp_d;
    end

    assign cmp_ready = ~pending_q;
    assign pwm_hi    = pwm_hi_q;

endmodule

// File: tb/tb_phase_pwm_gen.sv
module tb_phase_pwm_gen;

    localparam int N = 12;

    logic         clk = 1'b0;
    logic         rst, en, cmp_valid, cmp_ready;
    logic [N-1:0] period_in, cmp_a, cmp_b, cmp_c, carrier;
    logic [2:0]   pwm_hi;
    logic         valley, peak;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phase_pwm_gen #(.N(N), .PERIOD_MIN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cmp_valid (cmp_valid),
        .cmp_ready (cmp_ready),
        .period_in (period_in),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_c     (cmp_c),
        .pwm_hi    (pwm_hi),
        .carrier   (carrier),
        .valley    (valley),
        .peak      (peak)
    );

    // Reference model: position t within a 2P-clock period (t=0 at the valley),
    // carrier derived from t, a phase high when t lies in the 2C-wide window
    // around the valley.
    int         m_run, m_t, m_P, m_pend, sh_P;
    int         m_C[3];
    int         sh_C[3];
    int         e_car;
    logic [2:0] e_pwm;
    logic       e_valley, e_peak;

    task automatic m_reset();
        m_run = 0; m_t = 0; m_P = 2; m_pend = 0;
        for (int i = 0; i < 3; i++) m_C[i] = 0;
        e_car = 0; e_pwm = 3'b000; e_valley = 1'b0; e_peak = 1'b0;
    endtask

    task automatic m_step();
        int         nt, nrun;
        logic       acc, ld;
        logic [2:0] npwm;
        acc  = cmp_valid && (m_pend == 0);
        npwm = 3'b000;
        if (en && m_run != 0)
            for (int i = 0; i < 3; i++)
                npwm[i] = (m_t < m_C[i]) || (m_t >= 2 * m_P - m_C[i]);
        e_valley = 1'b0;
        e_peak   = 1'b0;
        if (!en) begin
            nrun = 0; nt = 0;
        end else if (m_run == 0) begin
            nrun = 1; nt = 0;
        end else begin
            nrun = 1;
            nt = (m_t + 1) % (2 * m_P);
            e_valley = (nt == 0);
            e_peak   = (nt == m_P);
        end
        ld = (m_pend != 0) && (m_run == 0 || e_valley);
        if (ld) begin
            m_P = sh_P;
            m_C = sh_C;
            m_pend = 0;
        end
        if (acc) begin
            sh_P = (int'(period_in) < 2) ? 2 : int'(period_in);
            sh_C[0] = int'(cmp_a); sh_C[1] = int'(cmp_b); sh_C[2] = int'(cmp_c);
            m_pend = 1;
        end
        m_run = nrun;
        m_t   = nt;
        e_pwm = npwm;
        e_car = (m_run == 0) ? 0 : ((m_t <= m_P) ? m_t : 2 * m_P - m_t);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset(); else m_step();
        #1;
    endtask

    task automatic offer(input int p, input int a, input int b, input int c);
        period_in = N'(p); cmp_a = N'(a); cmp_b = N'(b); cmp_c = N'(c);
        cmp_valid = 1'b1;
        tick();
        cmp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cmp_valid = 1'b0;
        period_in = '0; cmp_a = '0; cmp_b = '0; cmp_c = '0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (carrier !== '0)    begin n_fail++; $display("FAIL reset_carrier got %0d want 0", carrier); end
        n_checks++; if (pwm_hi !== 3'b000) begin n_fail++; $display("FAIL reset_pwm got %b want 000", pwm_hi); end
        n_checks++; if (valley !== 1'b0 || peak !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got v=%b p=%b want 0 0", valley, peak); end
        n_checks++; if (cmp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmp_ready); end
        tick();
        n_checks++; if (carrier !== '0 || pwm_hi !== 3'b000) begin n_fail++; $display("FAIL idle_hold got car=%0d pwm=%b want 0 000", carrier, pwm_hi); end
    endtask

    task automatic test_basic();
        int last_v, win, hi_a, hi_b, hi_c;
        offer(10, 5, 0, 10);
        n_checks++; if (cmp_ready !== 1'b0) begin n_fail++; $display("FAIL idle_accept_ready got %b want 0", cmp_ready); end
        tick();
        n_checks++; if (cmp_ready !== 1'b1) begin n_fail++; $display("FAIL idle_transfer_ready got %b want 1", cmp_ready); end
        en = 1'b1;
        last_v = -1; win = -1; hi_a = 0; hi_b = 0; hi_c = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_checks++;
            if (int'(carrier) !== e_car || pwm_hi !== e_pwm || valley !== e_valley || peak !== e_peak) begin
                n_fail++;
                $display("FAIL basic_cycle%0d got car=%0d pwm=%b v=%b p=%b want car=%0d pwm=%b v=%b p=%b",
                         i, carrier, pwm_hi, valley, peak, e_car, e_pwm, e_valley, e_peak);
            end
            if (win >= 0 && i > win && i <= win + 20) begin
                hi_a += int'(pwm_hi[0]); hi_b += int'(pwm_hi[1]); hi_c += int'(pwm_hi[2]);
            end
            if (valley) begin
                if (last_v >= 0) begin
                    n_checks++;
                    if (i - last_v != 20) begin n_fail++; $display("FAIL basic_period got %0d want 20", i - last_v); end
                end else begin
                    win = i;
                end
                last_v = i;
            end
        end
        n_checks++; if (hi_a != 10) begin n_fail++; $display("FAIL basic_high_a got %0d want 10", hi_a); end
        n_checks++; if (hi_b != 0)  begin n_fail++; $display("FAIL basic_high_b got %0d want 0", hi_b); end
        n_checks++; if (hi_c != 20) begin n_fail++; $display("FAIL basic_high_c got %0d want 20", hi_c); end
    endtask

    task automatic test_midperiod_update();
        int k, since_peak, hi_a;
        tick(); k = 0;
        while (!peak && k < 40) begin tick(); k++; end
        n_checks++; if (!peak) begin n_fail++; $display("FAIL mid_wait_peak got timeout want peak"); end
        since_peak = 0;
        tick(); tick(); since_peak += 2;
        n_checks++; if (cmp_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_before got %b want 1", cmp_ready); end
        offer(10, 2, 0, 10); since_peak++;
        k = 0;
        while (!valley && k < 30) begin
            n_checks++;
            if (cmp_ready !== 1'b0 || pwm_hi !== e_pwm) begin
                n_fail++; $display("FAIL mid_pending got rdy=%b pwm=%b want rdy=0 pwm=%b", cmp_ready, pwm_hi, e_pwm);
            end
            tick(); since_peak++; k++;
        end
        n_checks++; if (since_peak != 10) begin n_fail++; $display("FAIL mid_no_truncate got %0d want 10", since_peak); end
        n_checks++; if (cmp_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_at_valley got %b want 1", cmp_ready); end
        hi_a = 0;
        for (int i = 1; i <= 20; i++) begin tick(); hi_a += int'(pwm_hi[0]); end
        n_checks++; if (hi_a != 4) begin n_fail++; $display("FAIL mid_high_a got %0d want 4", hi_a); end
    endtask

    task automatic test_ignore_while_pending();
        int k, hi_a;
        offer(10, 3, 0, 10);
        n_checks++; if (cmp_ready !== 1'b0) begin n_fail++; $display("FAIL ign_ready got %b want 0", cmp_ready); end
        cmp_a = N'(7); cmp_valid = 1'b1;
        tick();
        cmp_valid = 1'b0;
        k = 0;
        while (!valley && k < 40) begin tick(); k++; end
        n_checks++; if (!valley) begin n_fail++; $display("FAIL ign_wait_valley got timeout want valley"); end
        hi_a = 0;
        for (int i = 1; i <= 20; i++) begin tick(); hi_a += int'(pwm_hi[0]); end
        n_checks++; if (hi_a != 6) begin n_fail++; $display("FAIL ign_high_a got %0d want 6", hi_a); end
        n_checks++; if (cmp_ready !== 1'b1) begin n_fail++; $display("FAIL ign_ready_after got %b want 1", cmp_ready); end
        offer(10, 7, 0, 10);
        tick(); k = 0;
        while (!valley && k < 40) begin tick(); k++; end
        hi_a = 0;
        for (int i = 1; i <= 20; i++) begin tick(); hi_a += int'(pwm_hi[0]); end
        n_checks++; if (hi_a != 14) begin n_fail++; $display("FAIL ign_late_offer_high_a got %0d want 14", hi_a); end
    endtask

    task automatic test_clamp();
        int k, t, exp_car, peaks;
        offer(1, 0, 0, 0);
        k = 0;
        while (!valley && k < 40) begin tick(); k++; end
        n_checks++; if (!valley) begin n_fail++; $display("FAIL clamp_wait_valley got timeout want valley"); end
        peaks = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            t = i % 4;
            exp_car = (t <= 2) ? t : 4 - t;
            n_checks++;
            if (int'(carrier) !== exp_car || peak !== (t == 2) || valley !== (t == 0)) begin
                n_fail++; $display("FAIL clamp_seq%0d got car=%0d p=%b v=%b want car=%0d p=%b v=%b",
                                   i, carrier, peak, valley, exp_car, (t == 2), (t == 0));
            end
            peaks += int'(peak);
        end
        n_checks++; if (peaks != 2) begin n_fail++; $display("FAIL clamp_peak_count got %0d want 2", peaks); end
    endtask

    task automatic test_en_drop();
        int k, prev;
        offer(10, 5, 0, 10);
        k = 0;
        while (!valley && k < 20) begin tick(); k++; end
        prev = -1; k = 0;
        while (!(int'(carrier) == 6 && prev == 5) && k < 40) begin prev = int'(carrier); tick(); k++; end
        n_checks++; if (int'(carrier) != 6) begin n_fail++; $display("FAIL drop_wait got car=%0d want 6", carrier); end
        en = 1'b0;
        tick();
        n_checks++;
        if (carrier !== '0 || pwm_hi !== 3'b000 || valley !== 1'b0 || peak !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle got car=%0d pwm=%b v=%b p=%b want 0 000 0 0", carrier, pwm_hi, valley, peak);
        end
        tick(); tick();
        n_checks++; if (carrier !== '0 || pwm_hi !== 3'b000) begin n_fail++; $display("FAIL drop_hold got car=%0d pwm=%b want 0 000", carrier, pwm_hi); end
        en = 1'b1;
        tick();
        n_checks++; if (carrier !== '0 || valley !== 1'b0) begin n_fail++; $display("FAIL restart_first got car=%0d v=%b want 0 0", carrier, valley); end
        tick();
        n_checks++; if (carrier !== N'(1) || pwm_hi !== e_pwm) begin n_fail++; $display("FAIL restart_second got car=%0d pwm=%b want 1 %b", carrier, pwm_hi, e_pwm); end
    endtask

    task automatic test_rst_pending();
        tick(); tick(); tick();
        offer(5, 1, 1, 1);
        n_checks++; if (cmp_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pend_accept got %b want 0", cmp_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (cmp_ready !== 1'b1 || carrier !== '0 || pwm_hi !== 3'b000 || valley !== 1'b0 || peak !== 1'b0) begin
            n_fail++; $display("FAIL rst_pend_clear got rdy=%b car=%0d pwm=%b want 1 0 000", cmp_ready, carrier, pwm_hi);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (int'(carrier) > 2 || pwm_hi !== 3'b000 || int'(carrier) !== e_car) begin
                n_fail++; $display("FAIL rst_pend_lost%0d got car=%0d pwm=%b want car=%0d pwm=000", i, carrier, pwm_hi, e_car);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 999) == 0);
            en        = ($urandom_range(0, 99) < 97);
            cmp_valid = ($urandom_range(0, 3) == 0);
            period_in = N'($urandom_range(0, 12));
            cmp_a     = N'($urandom_range(0, 14));
            cmp_b     = N'($urandom_range(0, 14));
            cmp_c     = N'($urandom_range(0, 14));
            tick();
            n_checks++;
            if (int'(carrier) !== e_car || pwm_hi !== e_pwm || valley !== e_valley ||
                peak !== e_peak || cmp_ready !== (m_pend == 0)) begin
                n_fail++;
                $display("FAIL random%0d got car=%0d pwm=%b v=%b p=%b rdy=%b want car=%0d pwm=%b v=%b p=%b rdy=%b",
                         i, carrier, pwm_hi, valley, peak, cmp_ready, e_car, e_pwm, e_valley, e_peak, (m_pend == 0));
            end
        end
        rst = 1'b0; cmp_valid = 1'b0;
    endtask

    initial begin
        m_reset();
        sh_P = 2;
        for (int i = 0; i < 3; i++) sh_C[i] = 0;
        test_reset();
        test_basic();
        test_midperiod_update();
        test_ignore_while_pending();
        test_clamp();
        test_en_drop();
        test_rst_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
